// File: rtl/hex_monitor.sv
// Multi-channel debug display: debounced channel select plus sequential
// double-dabble conversion onto active-low seven-segment digits.
module hex_monitor #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned VALUE_WIDTH     = 16,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [CHANNELS*VALUE_WIDTH-1:0]                   values,
  input  logic                                              btn_next_n,
  input  logic                                              hex_mode,
  input  logic                                              blank_lz,
  output logic [7*DIGITS-1:0]                               hex,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel,
  output logic                                              busy,
  output logic                                              overflow
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SC_W   = $clog2(VALUE_WIDTH);
  // Decimal digits of 2^VALUE_WIDTH-1: floor(W*log10(2)) + 1
  localparam int unsigned BCD_N  = (VALUE_WIDTH * 30103) / 100000 + 1;
  localparam int unsigned BCD_W  = 4 * BCD_N;
  localparam int unsigned DEC_N  = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int unsigned DEC_W  = 4 * DEC_N;
  localparam int unsigned HEX_NB = (VALUE_WIDTH + 3) / 4;
  localparam int unsigned HEX_N  = (HEX_NB > DIGITS) ? HEX_NB : DIGITS;
  localparam int unsigned HEX_W  = 4 * HEX_N;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic              sync1, sync2, acc, acc_d;
  logic [DB_W-1:0]   db_cnt;

  // Synchroniser and debouncer; accepted level idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      acc    <= 1'b1;
      acc_d  <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_next_n;
      sync2 <= sync1;
      acc_d <= acc;
      if (sync2 != acc) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          acc    <= ~acc;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Press (accepted 1->0) advances the channel with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      channel <= '0;
    end else if (acc_d && !acc) begin
      if (channel == CH_W'(CHANNELS - 1)) channel <= '0;
      else                                channel <= channel + CH_W'(1);
    end
  end

  logic [VALUE_WIDTH-1:0] sel_c;

  always_comb begin
    sel_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (channel == CH_W'(k)) sel_c = values[k*VALUE_WIDTH +: VALUE_WIDTH];
    end
  end

  state_t            state, next_state;
  logic              load_c, shift_c, done_c;
  logic [SC_W-1:0]   bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE:  next_state = LOAD;
      LOAD:  begin
        load_c     = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (bit_cnt == SC_W'(VALUE_WIDTH - 1)) next_state = DONE;
      end
      DONE:  begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  logic [VALUE_WIDTH-1:0] val, sh;
  logic [BCD_W-1:0]       bcd, adj_c;
  logic                   hex_s, blank_s;

  // Add-3 correction on every BCD nibble >= 5 before each shift
  always_comb begin
    adj_c = bcd;
    for (int n = 0; n < int'(BCD_N); n++) begin
      if (bcd[4*n +: 4] >= 4'd5) adj_c[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  logic [DEC_W-1:0] dec_pad;
  logic [HEX_W-1:0] hex_pad;
  logic [3:0]       nib;
  logic             lead;
  logic             ovf_c;
  logic [7*DIGITS-1:0] hex_c;

  // Digit selection, overflow detection and leading-zero blanking
  always_comb begin
    dec_pad = DEC_W'(bcd);
    hex_pad = HEX_W'(val);
    ovf_c   = 1'b0;
    hex_c   = '1;
    nib     = '0;
    lead    = blank_s;
    if (hex_s) begin
      for (int n = int'(DIGITS); n < int'(HEX_N); n++) ovf_c = ovf_c | (|hex_pad[4*n +: 4]);
    end else begin
      for (int n = int'(DIGITS); n < int'(DEC_N); n++) ovf_c = ovf_c | (|dec_pad[4*n +: 4]);
    end
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib = hex_s ? hex_pad[4*i +: 4] : dec_pad[4*i +: 4];
      if (ovf_c) begin
        hex_c[7*i +: 7] = SEG_DASH;
      end else if (lead && (i != 0) && (nib == 4'd0)) begin
        hex_c[7*i +: 7] = SEG_BLANK;
      end else begin
        lead            = 1'b0;
        hex_c[7*i +: 7] = seg7(nib);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val      <= '0;
      sh       <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      hex_s    <= 1'b0;
      blank_s  <= 1'b0;
      hex      <= '1;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      if (load_c) begin
        val     <= sel_c;
        sh      <= sel_c;
        hex_s   <= hex_mode;
        blank_s <= blank_lz;
        bcd     <= '0;
        bit_cnt <= '0;
      end
      if (shift_c) begin
        bcd     <= {adj_c[BCD_W-2:0], sh[VALUE_WIDTH-1]};
        sh      <= {sh[VALUE_WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + SC_W'(1);
      end
      if (done_c) begin
        hex      <= hex_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_hex_monitor.sv
// Directed bench for hex_monitor: reset, conversion timing, blanking,
// overflow, hex mode, debounce and mid-conversion channel/reset behaviour.
module tb_hex_monitor;
  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned DB = 4;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] SF  = 7'b0001110;
  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] DSH = 7'b0111111;

  logic            clk = 1'b0;
  logic            rst_n, btn_next_n, hex_mode, blank_lz;
  logic [CH*W-1:0] values;
  logic [7*D-1:0]  hex;
  logic [1:0]      channel;
  logic            busy, overflow;

  int total = 0;
  int bad   = 0;

  hex_monitor #(
    .CHANNELS(CH), .VALUE_WIDTH(W), .DIGITS(D), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .values(values), .btn_next_n(btn_next_n),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .hex(hex), .channel(channel),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic set_ch(input int k, input logic [15:0] v);
    values[k*W +: W] = v;
  endtask

  // Reset released just after a falling edge so the next rising edge is edge 1
  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    values = '0; set_ch(0, 16'd1234);
    hex_mode = 1'b0; blank_lz = 1'b0; btn_next_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (hex !== {4{BLK}}) begin bad++; $display("FAIL reset_hex: got %h expected %h", hex, {4{BLK}}); end
    total++; if (channel !== 2'd0) begin bad++; $display("FAIL reset_channel: got %0d expected 0", channel); end
    total++; if (busy !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%b ovf=%b expected 0 0", busy, overflow); end
    @(negedge clk); rst_n = 1'b1;
    edges(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_load: got %b expected 1", busy); end
    edges(17);
    total++; if (hex !== {4{BLK}}) begin bad++; $display("FAIL early_update: got %h expected %h at edge 18", hex, {4{BLK}}); end
    edges(1);
    exp = {S1, S2, S3, S4};
    total++; if (hex !== exp) begin bad++; $display("FAIL first_1234: got %h expected %h", hex, exp); end
    total++; if (overflow !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL first_flags: ovf=%b busy=%b expected 0 0", overflow, busy); end
  endtask

  task automatic test_blanking();
    logic [27:0] exp;
    set_ch(0, 16'd7); blank_lz = 1'b1;
    reset_dut(); edges(19);
    exp = {BLK, BLK, BLK, S7};
    total++; if (hex !== exp) begin bad++; $display("FAIL blank_on_7: got %h expected %h", hex, exp); end
    blank_lz = 1'b0;
    reset_dut(); edges(19);
    exp = {S0, S0, S0, S7};
    total++; if (hex !== exp) begin bad++; $display("FAIL blank_off_7: got %h expected %h", hex, exp); end
  endtask

  task automatic test_overflow_hex();
    logic [27:0] exp;
    set_ch(0, 16'd12345); hex_mode = 1'b0; blank_lz = 1'b0;
    reset_dut(); edges(19);
    exp = {4{DSH}};
    total++; if (hex !== exp || overflow !== 1'b1) begin bad++; $display("FAIL dec_ovf_12345: got %h ovf=%b expected %h ovf=1", hex, overflow, exp); end
    hex_mode = 1'b1;
    reset_dut(); edges(19);
    exp = {S3, S0, S3, S9};
    total++; if (hex !== exp || overflow !== 1'b0) begin bad++; $display("FAIL hex_3039: got %h ovf=%b expected %h ovf=0", hex, overflow, exp); end
    // Live input changes without reset, within the two-conversion latency
    hex_mode = 1'b0; set_ch(0, 16'd9999);
    edges(38);
    exp = {S9, S9, S9, S9};
    total++; if (hex !== exp || overflow !== 1'b0) begin bad++; $display("FAIL dec_9999: got %h ovf=%b expected %h ovf=0", hex, overflow, exp); end
    set_ch(0, 16'd10000);
    edges(38);
    exp = {4{DSH}};
    total++; if (hex !== exp || overflow !== 1'b1) begin bad++; $display("FAIL dec_10000: got %h ovf=%b expected %h ovf=1", hex, overflow, exp); end
    hex_mode = 1'b1; blank_lz = 1'b1; set_ch(0, 16'h00F0);
    edges(38);
    exp = {BLK, BLK, SF, S0};
    total++; if (hex !== exp || overflow !== 1'b0) begin bad++; $display("FAIL hex_00f0_blank: got %h ovf=%b expected %h ovf=0", hex, overflow, exp); end
    hex_mode = 1'b0; blank_lz = 1'b0;
  endtask

  task automatic test_debounce();
    logic [1:0] exp;
    btn_next_n = 1'b1;
    reset_dut(); edges(3);
    @(negedge clk); btn_next_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); btn_next_n = 1'b1;
    edges(12);
    total++; if (channel !== 2'd0) begin bad++; $display("FAIL glitch_ignored: got %0d expected 0", channel); end
    @(negedge clk); btn_next_n = 1'b0;
    edges(6);
    total++; if (channel !== 2'd0) begin bad++; $display("FAIL press_early: got %0d expected 0 at N+5", channel); end
    edges(1);
    total++; if (channel !== 2'd1) begin bad++; $display("FAIL press_n6: got %0d expected 1 at N+6", channel); end
    edges(20);
    total++; if (channel !== 2'd1) begin bad++; $display("FAIL held: got %0d expected 1", channel); end
    @(negedge clk); btn_next_n = 1'b1;
    edges(12);
    total++; if (channel !== 2'd1) begin bad++; $display("FAIL release: got %0d expected 1", channel); end
    for (int p = 2; p <= 4; p++) begin
      exp = 2'(p);
      @(negedge clk); btn_next_n = 1'b0;
      edges(12);
      total++; if (channel !== exp) begin bad++; $display("FAIL press_%0d: got %0d expected %0d", p, channel, exp); end
      @(negedge clk); btn_next_n = 1'b1;
      edges(12);
    end
  endtask

  task automatic test_channel_change();
    logic [27:0] exp;
    set_ch(0, 16'd1); set_ch(1, 16'd2); blank_lz = 1'b1; hex_mode = 1'b0; btn_next_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; btn_next_n = 1'b0;
    edges(6);
    total++; if (channel !== 2'd0) begin bad++; $display("FAIL mid_ch_early: got %0d expected 0", channel); end
    edges(1);
    total++; if (channel !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL mid_ch_switch: ch=%0d busy=%b expected 1 1", channel, busy); end
    edges(12);
    exp = {BLK, BLK, BLK, S1};
    total++; if (hex !== exp) begin bad++; $display("FAIL mid_ch_old: got %h expected %h", hex, exp); end
    @(negedge clk); btn_next_n = 1'b1;
    edges(19);
    exp = {BLK, BLK, BLK, S2};
    total++; if (hex !== exp) begin bad++; $display("FAIL mid_ch_new: got %h expected %h", hex, exp); end
  endtask

  task automatic test_reset_mid();
    set_ch(0, 16'd12345); hex_mode = 1'b0; blank_lz = 1'b0; btn_next_n = 1'b1;
    reset_dut(); edges(19);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pre_reset_ovf: got %b expected 1", overflow); end
    edges(8);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (hex !== {4{BLK}} || busy !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL async_reset: hex=%h busy=%b ovf=%b expected %h 0 0", hex, busy, overflow, {4{BLK}}); end
    @(negedge clk); rst_n = 1'b1;
    edges(18);
    total++; if (hex !== {4{BLK}}) begin bad++; $display("FAIL post_reset_early: got %h expected %h", hex, {4{BLK}}); end
    edges(1);
    total++; if (hex !== {4{DSH}} || overflow !== 1'b1) begin bad++; $display("FAIL post_reset_first: got %h ovf=%b expected %h ovf=1", hex, overflow, {4{DSH}}); end
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_overflow_hex();
    test_debounce();
    test_channel_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_monitor.md
# hex_monitor

Parametrised debug display block for the picoComputer board top level. It takes CHANNELS packed binary values, such as pc, sp and cpu output, and displays the selected one on DIGITS active-low seven-segment digits, in decimal or hex. A debounced pushbutton cycles through the channels. Binary-to-BCD conversion is sequential (double dabble, one bit per cycle), which replaces the fixed two-digit bcd/ssd pairs with one width-generic, multi-channel unit.

## Interface
- CHANNELS, 4, number of monitored values (≥1)
- VALUE_WIDTH, 16, bits per value (≥4)
- DIGITS, 4, seven-segment digits driven (≥1)
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level (≥1)
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- values  in  CHANNELS*VALUE_WIDTH  packed inputs; channel k = values[k*VALUE_WIDTH +: VALUE_WIDTH]
- btn_next_n  in  1  raw, asynchronous, active-low pushbutton
- hex_mode  in  1  1 = hexadecimal display, 0 = decimal
- blank_lz  in  1  1 = blank leading zero digits
- hex  out  7*DIGITS  digit i on hex[7i+6:7i]; digit 0 is least significant; active-low; bit0 = a … bit6 = g
- channel  out  max(1,$clog2(CHANNELS))  currently selected channel
- busy  out  1  conversion in progress
- overflow  out  1  last displayed value did not fit in DIGITS digits

## Operation
- **Button input**
  - btn_next_n passes through a 2-flop synchroniser.
  - The debouncer counts consecutive cycles where the synchronised level differs from the accepted level. When the count reaches DEBOUNCE_CYCLES, the accepted level flips. Any sample equal to the accepted level clears the count.
  - A 1→0 transition of the accepted level (a press) increments channel, wrapping from CHANNELS-1 to 0. Release has no effect.
  - With CHANNELS=1, channel stays at 0.
- **Conversion FSM**, states IDLE → LOAD → SHIFT → DONE → IDLE, running continuously:
  - IDLE: always moves to LOAD on the next edge.
  - LOAD: samples the selected channel value, hex_mode and blank_lz, and clears the BCD register.
  - SHIFT: runs exactly VALUE_WIDTH cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts the value MSB into the BCD register. The BCD register has enough nibbles for the full VALUE_WIDTH range.
  - DONE: updates hex and overflow, then returns to IDLE.
  - In hex mode the same FSM runs and the digits are the raw nibbles, so latency is identical in both modes.
- **Encoding**
  - Digits 0–9 and A–F (A, b, C, d, E, F) use standard segment patterns.
  - Example codes: 0 = 7'b1000000, 1 = 7'b1111001, F = 7'b0001110.
  - Blank = 7'h7F. Dash = 7'b0111111.
- **Overflow**
  - Decimal mode: overflow when value ≥ 10^DIGITS.
  - Hex mode: overflow when value bits above 4*DIGITS are nonzero.
  - On overflow, every digit shows a dash and overflow = 1.
- **Leading-zero blanking**: when blank_lz = 1, zero digits above the most significant nonzero digit are blank. Digit 0 is always shown. Blanking is ignored on overflow.
- **Channel change mid-conversion**: the running conversion completes with its sampled value. The next LOAD uses the new channel.

## Timing
- Reset values: channel = 0, busy = 0, overflow = 0, all hex digits 7'h7F. FSM in IDLE, debouncer accepted level = 1, counter = 0.
- With edge 1 as the first edge after rst_n deasserts:
  - LOAD occurs at edge 2 (sampling point).
  - hex and overflow update at edge VALUE_WIDTH+3.
  - The cycle repeats every VALUE_WIDTH+3 cycles.
- busy = 1 in LOAD, SHIFT and DONE; busy = 0 in IDLE.
- Display latency from an input change to hex: at most 2*(VALUE_WIDTH+3) cycles.
- A button held low from edge N updates channel at edge N+DEBOUNCE_CYCLES+2. This counts 2 synchroniser cycles, DEBOUNCE_CYCLES counting edges and 1 edge-detect register, minus 1 because counting overlaps the synchroniser output.
- A low pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Reset asserted mid-conversion or mid-debounce immediately restores every reset value. A partial conversion is discarded.

## Test plan
Bench parameters: CHANNELS=4, VALUE_WIDTH=16, DIGITS=4, DEBOUNCE_CYCLES=4.
- **Reset and first update**: rst_n low → hex all 7'h7F, channel 0. Release with ch0 = 1234 → at edge 19, digits 3..0 = 1111001, 0100100, 0110000, 0011001; overflow = 0.
- **Leading-zero blanking**: ch0 = 7 with blank_lz = 1 → digits 3..1 = 7'h7F, digit 0 = 1111000. With blank_lz = 0 → 1000000 ×3, then 1111000.
- **Overflow and hex mode**: ch0 = 12345 decimal → overflow = 1, all digits 0111111. Set hex_mode = 1 → 0x3039 shows 3, 0, 3, 9 with overflow = 0.
- **Debounce**
  - A 3-cycle low glitch leaves channel at 0.
  - Holding low from edge N gives channel = 1 at edge N+6, with no further change while held.
  - Four full presses wrap channel back to 0.
- **Channel change mid-conversion**: ch0 = 1, ch1 = 2. Press during SHIFT → the next update shows 1, and the following update shows 2.
- **Reset mid-conversion**: assert rst_n during SHIFT → hex = 7'h7F, busy = 0 immediately. After release, the first update arrives at edge 19.
